// File: rtl/floo_vc_sched_pkg.sv
// floo_vc_sched_pkg: shared helpers for the VC input scheduler (initial credit per VC, one-hot/binary conversion)
package floo_vc_sched_pkg;
  function automatic int init_credit(input int v, input int depth, input int deeper_id, input int deeper_depth);
    return (v == deeper_id) ? deeper_depth : depth;
  endfunction
  function automatic logic [31:0] bin2oh(input int unsigned idx);
    return 32'd1 << idx;
  endfunction
  function automatic int unsigned oh2bin(input logic [31:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) r = oh[i] ? i : r;
    return r;
  endfunction
endpackage

// File: rtl/floo_vc_rr_arbiter.sv
// floo_vc_rr_arbiter: combinational round-robin pick; in elig[NumVC], last_gnt; out gnt_oh[NumVC], gnt_id, valid
module floo_vc_rr_arbiter
  import floo_vc_sched_pkg::*;
#(
  parameter int NumVC = 4,
  parameter int NumVCWidth = 2
) (
  input  logic [NumVC-1:0]      elig,
  input  logic [NumVCWidth-1:0] last_gnt,
  output logic [NumVC-1:0]      gnt_oh,
  output logic [NumVCWidth-1:0] gnt_id,
  output logic                  valid
);
  int unsigned win, idx;
  logic [31:0] oh;
  always_comb begin
    win = 0;
    idx = 0;
    valid = 1'b0;
    for (int i = 1; i <= NumVC; i++) begin
      idx = (int'(last_gnt) + i) % NumVC;
      if (!valid && elig[idx]) begin
        valid = 1'b1;
        win = idx;
      end
    end
  end
  assign oh = bin2oh(win);
  assign gnt_oh = oh[NumVC-1:0] & {NumVC{valid}};
  assign gnt_id = NumVCWidth'(oh2bin(oh));
endmodule

// File: rtl/floo_vc_input_scheduler.sv
// floo_vc_input_scheduler: per-input-port VC scheduler with downstream credits; ports clk_i, rst_i, vc_head_v_i, sa_req_o/sa_vc_id_o/sa_gnt_i, read_*_sa_o, read_*_st_o, credit_v_i/credit_id_i, credit_o, err_o (FLOO_VC_SCHED_CREDIT_CHECK_EN enables sticky err_o)
module floo_vc_input_scheduler
  import floo_vc_sched_pkg::*;
#(
  parameter int NumVC = 4,
  parameter int NumVCWidth = 2,
  parameter int VCDepth = 3,
  parameter int DeeperVCId = 0,
  parameter int DeeperVCDepth = 2,
  parameter int CreditWidth = $clog2(((VCDepth > DeeperVCDepth) ? VCDepth : DeeperVCDepth) + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumVC-1:0]             vc_head_v_i,
  output logic                         sa_req_o,
  output logic [NumVCWidth-1:0]        sa_vc_id_o,
  input  logic                         sa_gnt_i,
  output logic                         read_enable_sa_o,
  output logic [NumVC-1:0]             read_vc_id_oh_sa_o,
  output logic                         read_enable_st_o,
  output logic [NumVC-1:0]             read_vc_id_oh_st_o,
  input  logic                         credit_v_i,
  input  logic [NumVCWidth-1:0]        credit_id_i,
  output logic [NumVC*CreditWidth-1:0] credit_o,
  output logic                         err_o
);
  logic [CreditWidth-1:0] credit_q [NumVC];
  logic [NumVC-1:0] elig, match, full, dec, win_oh;
  logic [NumVCWidth-1:0] last_gnt_q, win_id;
  logic win_v, gnt;
  floo_vc_rr_arbiter #(.NumVC(NumVC), .NumVCWidth(NumVCWidth)) u_arb (
    .elig(elig),
    .last_gnt(last_gnt_q),
    .gnt_oh(win_oh),
    .gnt_id(win_id),
    .valid(win_v)
  );
  assign gnt = win_v & sa_gnt_i;
  assign sa_req_o = win_v;
  assign sa_vc_id_o = win_id;
  assign read_enable_sa_o = gnt;
  assign read_vc_id_oh_sa_o = gnt ? win_oh : '0;
  for (genvar v = 0; v < NumVC; v++) begin : g_vc
    localparam logic [CreditWidth-1:0] Init = CreditWidth'(init_credit(v, VCDepth, DeeperVCId, DeeperVCDepth));
    assign match[v] = credit_v_i & (credit_id_i == NumVCWidth'(v));
    assign full[v] = credit_q[v] == Init;
    assign elig[v] = vc_head_v_i[v] & (credit_q[v] != '0);
    assign dec[v] = gnt & win_oh[v];
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) credit_q[v] <= Init;
      else if (match[v] && !dec[v] && !full[v]) credit_q[v] <= credit_q[v] + 1'b1;
      else if (dec[v] && !match[v]) credit_q[v] <= credit_q[v] - 1'b1;
    assign credit_o[v*CreditWidth +: CreditWidth] = credit_q[v];
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      last_gnt_q <= NumVCWidth'(NumVC - 1);
      read_enable_st_o <= 1'b0;
      read_vc_id_oh_st_o <= '0;
    end else begin
      if (gnt) last_gnt_q <= win_id;
      read_enable_st_o <= gnt;
      read_vc_id_oh_st_o <= read_vc_id_oh_sa_o;
    end
`ifdef FLOO_VC_SCHED_CREDIT_CHECK_EN
  logic ovf, err_q;
  always_comb begin
    ovf = credit_v_i & (int'(credit_id_i) >= NumVC);
    for (int i = 0; i < NumVC; i++) ovf = ovf | (match[i] & full[i]);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) err_q <= 1'b0;
    else if (ovf) err_q <= 1'b1;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_floo_vc_input_scheduler.sv
// tb_floo_vc_input_scheduler: directed self-checking bench for floo_vc_input_scheduler
module tb_floo_vc_input_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] vc_head_v = '0;
  logic sa_gnt = 1'b0, credit_v = 1'b0;
  logic [1:0] credit_id = '0;
  logic sa_req, re_sa, re_st, err;
  logic [1:0] sa_vc_id;
  logic [3:0] oh_sa, oh_st;
  logic [7:0] credit;
  int checks = 0, errors = 0;
  logic exp_err;
  floo_vc_input_scheduler dut (
    .clk_i(clk),
    .rst_i(rst),
    .vc_head_v_i(vc_head_v),
    .sa_req_o(sa_req),
    .sa_vc_id_o(sa_vc_id),
    .sa_gnt_i(sa_gnt),
    .read_enable_sa_o(re_sa),
    .read_vc_id_oh_sa_o(oh_sa),
    .read_enable_st_o(re_st),
    .read_vc_id_oh_st_o(oh_st),
    .credit_v_i(credit_v),
    .credit_id_i(credit_id),
    .credit_o(credit),
    .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
`ifdef FLOO_VC_SCHED_CREDIT_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    @(negedge clk);
    chk("rst_credit", credit, 8'hFE);
    chk("rst_re_st", re_st, 0);
    chk("rst_oh_st", oh_st, 0);
    chk("rst_err", err, 0);
    chk("rst_req", sa_req, 0);
    tick();
    rst = 1'b0;
    vc_head_v = 4'hF;
    sa_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_req", sa_req, 1);
      chk("rr_id", sa_vc_id, k);
      chk("rr_re_sa", re_sa, 1);
      chk("rr_oh_sa", oh_sa, 1 << k);
      if (k > 0) begin
        chk("rr_re_st", re_st, 1);
        chk("rr_oh_st", oh_st, 1 << (k - 1));
      end
      tick();
    end
    vc_head_v = 4'h0;
    sa_gnt = 1'b0;
    @(negedge clk);
    chk("rr_last_re_st", re_st, 1);
    chk("rr_last_oh_st", oh_st, 4'h8);
    chk("rr_credit", credit, 8'hA9);
    chk("rr_idle_req", sa_req, 0);
    tick();
    do_reset();
    vc_head_v = 4'h1;
    sa_gnt = 1'b1;
    @(negedge clk);
    chk("vc0_req_a", sa_req, 1);
    chk("vc0_id_a", sa_vc_id, 0);
    tick();
    @(negedge clk);
    chk("vc0_req_b", sa_req, 1);
    chk("vc0_id_b", sa_vc_id, 0);
    tick();
    credit_v = 1'b1;
    credit_id = 2'd0;
    @(negedge clk);
    chk("vc0_empty_credit", credit, 8'hFC);
    chk("vc0_empty_req", sa_req, 0);
    chk("vc0_empty_re_sa", re_sa, 0);
    tick();
    credit_v = 1'b0;
    @(negedge clk);
    chk("vc0_ret_req", sa_req, 1);
    chk("vc0_ret_credit", credit, 8'hFD);
    sa_gnt = 1'b0;
    vc_head_v = 4'h2;
    sa_gnt = 1'b1;
    tick();
    tick();
    credit_v = 1'b1;
    credit_id = 2'd1;
    @(negedge clk);
    chk("same_pre_credit", credit, 8'hF5);
    chk("same_req", sa_req, 1);
    chk("same_id", sa_vc_id, 1);
    tick();
    credit_v = 1'b0;
    sa_gnt = 1'b0;
    vc_head_v = 4'h0;
    @(negedge clk);
    chk("same_post_credit", credit, 8'hF5);
    chk("same_oh_st", oh_st, 4'h2);
    vc_head_v = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_req", sa_req, 1);
      chk("hold_id", sa_vc_id, 2);
      chk("hold_re_sa", re_sa, 0);
      chk("hold_oh_sa", oh_sa, 0);
      chk("hold_credit", credit, 8'hF5);
      if (k > 0) chk("hold_re_st", re_st, 0);
      tick();
    end
    sa_gnt = 1'b1;
    @(negedge clk);
    chk("hold_gnt_id", sa_vc_id, 2);
    chk("hold_gnt_re_sa", re_sa, 1);
    tick();
    sa_gnt = 1'b0;
    vc_head_v = 4'h0;
    @(negedge clk);
    chk("hold_gnt_credit", credit, 8'hE5);
    chk("hold_gnt_oh_st", oh_st, 4'h4);
    do_reset();
    credit_v = 1'b1;
    credit_id = 2'd2;
    tick();
    credit_v = 1'b0;
    @(negedge clk);
    chk("sat_credit", credit, 8'hFE);
    chk("sat_err", err, exp_err);
    tick();
    vc_head_v = 4'h1;
    sa_gnt = 1'b1;
    tick();
    vc_head_v = 4'h0;
    sa_gnt = 1'b0;
    chk("arst_pre_re_st", re_st, 1);
    chk("arst_pre_credit", credit, 8'hFD);
    rst = 1'b1;
    #1;
    chk("arst_re_st", re_st, 0);
    chk("arst_oh_st", oh_st, 0);
    chk("arst_credit", credit, 8'hFE);
    chk("arst_err", err, 0);
    tick();
    rst = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
